// File: rtl/dmp_pkg.sv
// rtl/dmp_pkg.sv - shared state encoding and mux select constants for the GCD processor
package dmp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        SUB_X = 3'd3,
        SUB_Y = 3'd4,
        OUT   = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic SEL_EXT = 1'b1;
    localparam logic SEL_SUB = 1'b0;

endpackage

// File: rtl/gcd_controller_if.sv
// rtl/gcd_controller_if.sv - host handshake, datapath status and control lines of the GCD controller
interface gcd_controller_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             ack;
    logic             x_eq_y;
    logic             x_gt_y;
    logic             x_zero;
    logic             y_zero;
    logic             x_sel;
    logic             y_sel;
    logic             x_ld;
    logic             y_ld;
    logic             out_ld;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] iter;

    modport master (
        input  start, ack, x_eq_y, x_gt_y, x_zero, y_zero,
        output x_sel, y_sel, x_ld, y_ld, out_ld, busy, done, err, iter
    );

    modport slave (
        output start, ack, x_eq_y, x_gt_y, x_zero, y_zero,
        input  x_sel, y_sel, x_ld, y_ld, out_ld, busy, done, err, iter
    );

endinterface

// File: rtl/iter_counter.sv
// rtl/iter_counter.sv - saturating subtract-step counter with sync clear and terminal flag
module iter_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    assign term = &count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && !term) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/gcd_controller.sv
// rtl/gcd_controller.sv - Moore FSM sequencing the 8-bit subtractive GCD datapath
// Optional iteration timeout is built only when GCD_TIMEOUT_EN is defined.
module gcd_controller
    import dmp_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int MAX_ITER = 255
) (
    input  logic             clk,
    input  logic             reset,
    gcd_controller_if.master bus
);

    state_t           state;
    state_t           state_nxt;
    logic             err_q;
    logic [CNT_W-1:0] iter_q;
    logic             iter_term;
    logic             timeout;
    logic             zero_op;

    if (MAX_ITER < 1 || MAX_ITER > (1 << CNT_W) - 1) begin : g_max_iter_range
        $error("MAX_ITER must fit the iteration counter");
    end

`ifdef GCD_TIMEOUT_EN
    assign timeout = (iter_q >= CNT_W'(MAX_ITER));
`else
    assign timeout = 1'b0;
`endif

    assign zero_op = bus.x_zero | bus.y_zero;

    iter_counter #(.CNT_W(CNT_W)) u_iter (
        .clk   (clk),
        .reset (reset),
        .clr   (state == LOAD),
        .en    ((state == SUB_X || state == SUB_Y) && !iter_term),
        .count (iter_q),
        .term  (iter_term)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // err is captured on the TEST exit so it can be presented from a register while in DONE
    always_ff @(posedge clk) begin
        if (reset || state == LOAD) begin
            err_q <= 1'b0;
        end else if (state == TEST && (zero_op || timeout)) begin
            err_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = LOAD;
            LOAD:    state_nxt = TEST;
            TEST: begin
                if (zero_op)         state_nxt = DONE;
                else if (timeout)    state_nxt = DONE;
                else if (bus.x_eq_y) state_nxt = OUT;
                else if (bus.x_gt_y) state_nxt = SUB_X;
                else                 state_nxt = SUB_Y;
            end
            SUB_X:   state_nxt = TEST;
            SUB_Y:   state_nxt = TEST;
            OUT:     state_nxt = DONE;
            DONE:    if (bus.ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    logic x_sel_c, y_sel_c, x_ld_c, y_ld_c, out_ld_c;

    always_comb begin
        x_sel_c  = SEL_SUB;
        y_sel_c  = SEL_SUB;
        x_ld_c   = 1'b0;
        y_ld_c   = 1'b0;
        out_ld_c = 1'b0;
        case (state)
            LOAD: begin
                x_sel_c = SEL_EXT;
                y_sel_c = SEL_EXT;
                x_ld_c  = 1'b1;
                y_ld_c  = 1'b1;
            end
            SUB_X:   x_ld_c   = 1'b1;
            SUB_Y:   y_ld_c   = 1'b1;
            OUT:     out_ld_c = 1'b1;
            default: ;
        endcase
    end

    assign bus.x_sel  = x_sel_c;
    assign bus.y_sel  = y_sel_c;
    assign bus.x_ld   = x_ld_c;
    assign bus.y_ld   = y_ld_c;
    assign bus.out_ld = out_ld_c;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.err    = (state == DONE) && err_q;
    assign bus.iter   = iter_q;

endmodule
